// File: rtl/prbs8_checker.sv
// ---------------------------------------------------------------------------
// prbs8_checker
//
// Receive-side checker for the 8-bit LFSR byte stream of the random
// generator. In SEARCH it reseeds its predictor from the incoming data until
// LOCK_CNT consecutive predictions hit. It then flywheels its own LFSR copy in
// LOCKED and flags every byte that disagrees. After LOSS_CNT consecutive
// misses it falls back to SEARCH.
//
// Step function: nxt(s) = {s[4]^s[3]^s[2]^s[0], s[7:1]}
//
// Build option:
//   PRBS8_BIT_ERR_EN  when defined, err_cnt accumulates the number of
//                     differing bits per LOCKED mismatch instead of 1 per byte.
//
// Parameters:
//   LOCK_CNT  consecutive SEARCH matches needed to lock (1..15)
//   LOSS_CNT  consecutive LOCKED mismatches that drop lock (1..15)
//   ERR_W     width of err_cnt
//
// Ports:
//   clk        in   clock, posedge
//   rst        in   asynchronous reset, active low
//   in_valid   in   in_data is valid; invalid cycles do not advance the checker
//   in_data    in   received LFSR byte
//   clr_cnt    in   synchronous clear of err_cnt (wins over an increment)
//   locked     out  1 while the FSM is in LOCKED
//   err_pulse  out  one-cycle pulse after a LOCKED mismatch is sampled
//   err_cnt    out  saturating error count
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module prbs8_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             err_hit;
    logic [3:0]       err_inc;
    logic [3:0]       run_inc;
    logic [3:0]       miss_inc;

    // One LFSR step.
    function automatic logic [7:0] nxt(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    // Number of set bits in a byte (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Add a small increment to the counter, clamping at all-ones.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt,
                                                 input logic [3:0]       inc);
        logic [ERR_W+3:0] sum;
        sum = {4'd0, cnt} + {{ERR_W{1'b0}}, inc};
        if (sum[ERR_W+3:ERR_W] != 4'd0) begin
            return {ERR_W{1'b1}};
        end
        return sum[ERR_W-1:0];
    endfunction

    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

`ifdef PRBS8_BIT_ERR_EN
    assign err_inc = popcount8(in_data ^ pred_q);
`else
    assign err_inc = 4'd1;
`endif

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_hit = 1'b0;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (in_data == 8'h00) begin
                        // All-zero is not a reachable LFSR state: break the run
                        // but keep the current prediction.
                        run_d = 4'd0;
                    end else if (in_data == pred_q) begin
                        // in_data is non-zero here, so pred_q is non-zero too.
                        pred_d = nxt(in_data);
                        if (run_inc == LOCK_C) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                            miss_d  = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d  = 4'd0;
                        pred_d = nxt(in_data);
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor never takes the received data.
                    pred_d = nxt(pred_q);
                    if (in_data == pred_q) begin
                        miss_d = 4'd0;
                    end else begin
                        err_hit = 1'b1;
                        if (miss_inc == LOSS_C) begin
                            state_d = SEARCH;
                            run_d   = 4'd0;
                            miss_d  = 4'd0;
                            pred_d  = nxt(in_data);
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end

        locked_d    = (state_d == LOCKED);
        err_pulse_d = err_hit;

        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_hit) begin
            err_cnt_d = sat_add(err_cnt_q, err_inc);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            pred_q      <= 8'h00;
            run_q       <= 4'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs8_checker
//
// Directed bench for prbs8_checker (LOCK_CNT=4, LOSS_CNT=3, ERR_W=4).
// The bench tracks the true generator sequence itself and keeps its own
// expected error count; with PRBS8_BIT_ERR_EN defined the expected increment
// becomes the number of differing bits.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_prbs8_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr_cnt;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_cnt;

    logic [7:0] gen;
    logic [3:0] exp_cnt;
    int         vectors     = 0;
    int         miscompares = 0;

    prbs8_checker #(
        .LOCK_CNT(4),
        .LOSS_CNT(3),
        .ERR_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    function automatic int inc_of(input logic [7:0] got, input logic [7:0] want);
`ifdef PRBS8_BIT_ERR_EN
        return $countones(got ^ want);
`else
        return (got != want) ? 1 : 0;
`endif
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] c, input int inc);
        int s;
        s = int'(c) + inc;
        return (s > 15) ? 4'hF : 4'(s);
    endfunction

    // A byte guaranteed to differ from the generator's current output.
    function automatic logic [7:0] wrong_of(input logic [7:0] g);
        return (g == 8'hAA) ? 8'h55 : 8'hAA;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present one valid byte, then return #1 after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic good();
        send(gen);
        gen = nxt8(gen);
    endtask

    task automatic bad(input logic [7:0] w);
        exp_cnt = sat4(exp_cnt, inc_of(w, gen));
        send(w);
        gen = nxt8(gen);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr_cnt  = 1'b0;
        gen      = 8'h00;
        exp_cnt  = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_pulse", 32'(err_pulse), 32'd0);
        chk("reset_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Lock on FF,7F,3F,1F,0F.
        send(8'hFF);
        send(8'h7F);
        send(8'h3F);
        send(8'h1F);
        chk("t1_not_yet", 32'(locked), 32'd0);
        send(8'h0F);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_cnt", 32'(err_cnt), 32'd0);
        gen = nxt8(8'h0F);

        // Two good bytes, then 00 in place of the third, then the correct next.
        good();
        good();
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_nopulse", 32'(err_pulse), 32'd0);
        bad(8'h00);
        chk("t2_pulse", 32'(err_pulse), 32'd1);
        chk("t2_cnt", 32'(err_cnt), 32'(exp_cnt));
        good();
        chk("t2_pulse_gone", 32'(err_pulse), 32'd0);
        chk("t2_cnt_hold", 32'(err_cnt), 32'(exp_cnt));
        chk("t2_still_locked", 32'(locked), 32'd1);

        // Three consecutive wrong bytes drop lock.
        bad(wrong_of(gen));
        chk("t3_pulse1", 32'(err_pulse), 32'd1);
        chk("t3_locked1", 32'(locked), 32'd1);
        bad(wrong_of(gen));
        chk("t3_pulse2", 32'(err_pulse), 32'd1);
        chk("t3_locked2", 32'(locked), 32'd1);
        bad(wrong_of(gen));
        chk("t3_pulse3", 32'(err_pulse), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        chk("t3_cnt", 32'(err_cnt), 32'(exp_cnt));
        @(posedge clk);
        #1;
        chk("t3_idle_pulse", 32'(err_pulse), 32'd0);
        // Relock on a clean sequence: reseed byte plus four matches.
        gen = 8'hFF;
        good();
        good();
        good();
        good();
        chk("t3_relock_early", 32'(locked), 32'd0);
        good();
        chk("t3_relocked", 32'(locked), 32'd1);

        // Async reset, then SEARCH with an illegal 00 in the stream.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_rst_locked", 32'(locked), 32'd0);
        chk("t4_rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        exp_cnt = 4'd0;
        send(8'hFF);
        send(8'h7F);
        send(8'h00);
        send(8'h3F);
        send(8'h1F);
        send(8'h0F);
        chk("t4_no_lock", 32'(locked), 32'd0);
        chk("t4_search_pulse", 32'(err_pulse), 32'd0);
        send(8'h87);
        chk("t4_locked", 32'(locked), 32'd1);
        chk("t4_cnt", 32'(err_cnt), 32'd0);
        gen = nxt8(8'h87);

        // Drive the counter into saturation without losing lock.
        for (int r = 0; r < 8; r++) begin
            bad(wrong_of(gen));
            bad(wrong_of(gen));
            good();
        end
        chk("t5_locked", 32'(locked), 32'd1);
        chk("t5_cnt_sat", 32'(err_cnt), 32'(exp_cnt));
        bad(wrong_of(gen));
        chk("t5_cnt_hold", 32'(err_cnt), 32'hF);
        good();
        // Clear coincident with a mismatch.
        clr_cnt = 1'b1;
        bad(wrong_of(gen));
        clr_cnt = 1'b0;
        exp_cnt = 4'd0;
        chk("t5_clr_cnt", 32'(err_cnt), 32'd0);
        chk("t5_clr_pulse", 32'(err_pulse), 32'd1);
        chk("t5_clr_locked", 32'(locked), 32'd1);
        good();

        // Valid gaps of 1..5 cycles while locked.
        for (int g = 1; g <= 5; g++) begin
            good();
            repeat (g) begin
                @(posedge clk);
                #1;
                chk("t6_gap_pulse", 32'(err_pulse), 32'd0);
            end
        end
        chk("t6_gap_locked", 32'(locked), 32'd1);
        chk("t6_gap_cnt", 32'(err_cnt), 32'd0);
        bad(wrong_of(gen));
        chk("t6_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        // One-cycle async reset mid-stream.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_cnt", 32'(err_cnt), 32'd0);
        chk("t6_rst_pulse", 32'(err_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        good();
        good();
        good();
        good();
        chk("t6_relock_early", 32'(locked), 32'd0);
        good();
        chk("t6_relocked", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
